// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller driving a simple dual-port RAM
// (one write port, one registered read port with 1-cycle read latency).
// The controller owns the pointers, occupancy and status flags; read data
// comes straight from the RAM, and pop_valid marks the cycle it is valid.
//
// Optional build macro: FIFO_CTRL_ERR_EN adds sticky ovf/udf error outputs
// (push while full / pop while empty). Without it, rejected requests are
// dropped silently and the ports do not exist.

module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDRSIZE   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [ADDRSIZE:0]     count,
    output logic                  pop_valid,
    output logic                  mem_wr_en,
    output logic [ADDRSIZE-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDRSIZE-1:0]   mem_rd_addr
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic                  ovf,
    output logic                  udf
`endif
);

    // Pointers carry one extra bit so they wrap modulo 2*DEPTH.
    localparam int               PTR_W    = ADDRSIZE + 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             pop_valid_q, pop_valid_d;
    logic             push_acc;
    logic             pop_acc;

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
`endif

    // Acceptance gates use the registered flags, so a push into a full FIFO
    // is dropped even if a pop frees a slot in the same cycle (and likewise
    // there is no empty-FIFO bypass). This also guarantees a write never
    // targets the slot being read in the same cycle.
    assign push_acc = push & ~full_q;
    assign pop_acc  = pop  & ~empty_q;

    // RAM drive: addresses are the low pointer bits, enables are acceptances.
    assign mem_wr_en   = push_acc;
    assign mem_wr_addr = wr_ptr_q[ADDRSIZE-1:0];
    assign mem_wr_data = push_data;
    assign mem_rd_en   = pop_acc;
    assign mem_rd_addr = rd_ptr_q[ADDRSIZE-1:0];

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign pop_valid = pop_valid_q;

`ifdef FIFO_CTRL_ERR_EN
    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

    // Next-state: pointer advance, occupancy update and flags derived from
    // the new occupancy so they stay in step with count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;

        if (push_acc) wr_ptr_d = wr_ptr_q + ONE;
        if (pop_acc)  rd_ptr_d = rd_ptr_q + ONE;

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
    end

`ifdef FIFO_CTRL_ERR_EN
    // Sticky error flags: once set, only reset clears them.
    always_comb begin
        ovf_d = ovf_q | (push & full_q);
        udf_d = udf_q | (pop & empty_q);
    end
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            // NOTE: only the pointers are reset; the RAM behind them is not
            // cleared, since its contents are unreachable once the pointers
            // say the FIFO is empty.
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pop_valid_q <= 1'b0;
`ifdef FIFO_CTRL_ERR_EN
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pop_valid_q <= pop_valid_d;
`ifdef FIFO_CTRL_ERR_EN
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
`endif
        end
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the team's simple dual-port RAM (1 write port, 1 registered read port, 1-cycle read latency).
- Owns write/read pointers, occupancy and status flags, and drives the RAM's write-enable/address/data and read-enable/address.
- Read data comes from the RAM's rd_data; this block supplies pop_valid, aligned to that data.

Parameters:
- DATA_WIDTH, 8, width of pushed words; passed through to mem_wr_data.
- DEPTH, 16, number of entries; must be a power of 2, >= 2.
- ADDRSIZE, $clog2(DEPTH), RAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset; one clock for the whole block.
- push  in  1  producer write request.
- push_data  in  DATA_WIDTH  word to store.
- pop  in  1  consumer read request.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  ADDRSIZE+1  current occupancy, 0..DEPTH.
- pop_valid  out  1  RAM rd_data holds a popped word this cycle.
- mem_wr_en  out  1  to RAM wr_en.
- mem_wr_addr  out  ADDRSIZE  to RAM wr_addr.
- mem_wr_data  out  DATA_WIDTH  to RAM wr_data.
- mem_rd_en  out  1  to RAM rd_en.
- mem_rd_addr  out  ADDRSIZE  to RAM rd_addr.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_valid=0.
  - Flags and outputs keep these values while rst_n is held low.
  - Reset mid-operation discards all contents; RAM contents are not cleared, only pointers.
- Pointers:
  - wr_ptr and rd_ptr are ADDRSIZE+1 bits; the low ADDRSIZE bits give the RAM address.
  - Each pointer increments by 1 per accepted operation and wraps naturally modulo 2*DEPTH.
- Acceptance (combinational):
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
- RAM drive (combinational):
  - mem_wr_en = push_acc, mem_wr_addr = wr_ptr[ADDRSIZE-1:0], mem_wr_data = push_data.
  - mem_rd_en = pop_acc, mem_rd_addr = rd_ptr[ADDRSIZE-1:0].
- Latency:
  - pop_valid is registered: pop_valid = pop_acc delayed one cycle, matching the RAM's 1-cycle read latency.
  - A word pushed in cycle N is poppable from cycle N+1; its earliest pop_valid is in cycle N+2.
- count updates on each edge:
  - +1 on push_acc only.
  - -1 on pop_acc only.
  - Unchanged on both or neither.
- Flags: empty = (count==0) and full = (count==DEPTH), both registered in step with count.
- Simultaneous push and pop:
  - Not full and not empty: both accepted; count unchanged; both pointers advance.
  - Full: pop accepted, push rejected; count becomes DEPTH-1.
  - Empty: push accepted, pop rejected (no bypass path); count becomes 1.
- Rejected operations change no state and produce no RAM enable.
- No same-address read/write in the same cycle: an accepted write while non-full never targets an unread slot.

Optional Feature:
- Macro: FIFO_CTRL_ERR_EN.
- When defined, two extra outputs are present:
  - ovf (1 bit): sticky; set on the clock after push & full.
  - udf (1 bit): sticky; set on the clock after pop & empty.
  - Both are cleared only by reset (reset value 0).
- When not defined, these ports and their logic do not exist; rejected requests are silently dropped.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release -> empty=1, full=0, count=0, pop_valid=0, mem_wr_en=mem_rd_en=0.
- Single word: push 0xA5 once, pop next cycle -> mem_wr_addr=0; mem_rd_addr=0; pop_valid=1 one cycle after pop, RAM rd_data=0xA5; count 0->1->0.
- Fill, DEPTH=16: push 0x00..0x0F -> count=16, full=1; a 17th push gives mem_wr_en=0 and count stays 16 (with FIFO_CTRL_ERR_EN: ovf=1 next cycle).
- Drain and wrap: pop all 16 in order, then push/pop 20 more words -> data in order 0x00..0x0F, then the new words; addresses wrap 15->0; empty=1 at end.
- Simultaneous push and pop:
  - At count=5: count stays 5.
  - At full: count goes to 15 and the push is dropped.
  - At empty: count goes to 1, mem_rd_en=0, pop_valid stays 0.
- Reset mid-stream at count=7 -> next cycle count=0, empty=1, pop_valid=0; next push writes address 0.
